// File: rtl/hamming_code_encoder_7_4.sv
// Hamming(7,4) encoder with optional registered output stage (OUT_REG).
// Define HAM_ENC_SECDED_EN to add code_p0, the overall even-parity bit for (8,4) SECDED.
module hamming_code_encoder_7_4 #(
    parameter bit OUT_REG = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [4:1] data_in,
    output logic       out_valid,
`ifdef HAM_ENC_SECDED_EN
    output logic       code_p0,
`endif
    output logic [7:1] code_out
);

    localparam int unsigned CODE_W = 7;

    // Parity bits cover the codeword positions whose index has bit 0, 1, 2 set.
    logic p1;
    logic p2;
    logic p3;
    logic [CODE_W:1] code_d;

    assign p1 = data_in[1] ^ data_in[2] ^ data_in[4];
    assign p2 = data_in[1] ^ data_in[3] ^ data_in[4];
    assign p3 = data_in[2] ^ data_in[3] ^ data_in[4];

    assign code_d = {data_in[4], data_in[3], data_in[2], p3, data_in[1], p2, p1};

`ifdef HAM_ENC_SECDED_EN
    logic p0_d;
    assign p0_d = ^code_d;
`endif

    generate
        if (OUT_REG) begin : g_reg
            logic [CODE_W:1] code_q;
            logic            valid_q;
`ifdef HAM_ENC_SECDED_EN
            logic            p0_q;
`endif

            // Capture only on valid so idle-cycle data never reaches the output.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    code_q  <= '0;
                    valid_q <= 1'b0;
`ifdef HAM_ENC_SECDED_EN
                    p0_q    <= 1'b0;
`endif
                end else begin
                    valid_q <= in_valid;
                    if (in_valid) begin
                        code_q <= code_d;
`ifdef HAM_ENC_SECDED_EN
                        p0_q   <= p0_d;
`endif
                    end
                end
            end

            assign code_out  = code_q;
            assign out_valid = valid_q;
`ifdef HAM_ENC_SECDED_EN
            assign code_p0   = p0_q;
`endif
        end else begin : g_comb
            assign code_out  = code_d;
            assign out_valid = in_valid;
`ifdef HAM_ENC_SECDED_EN
            assign code_p0   = p0_d;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_hamming_code_encoder_7_4.sv
// Bench for hamming_code_encoder_7_4 (OUT_REG=1) against a position-based Hamming model.
module tb_hamming_code_encoder_7_4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [4:1] data_in;
    logic       out_valid;
    logic [7:1] code_out;
`ifdef HAM_ENC_SECDED_EN
    logic       code_p0;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:1] exp_code;
    logic       exp_valid;

    hamming_code_encoder_7_4 #(.OUT_REG(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid),
`ifdef HAM_ENC_SECDED_EN
        .code_p0   (code_p0),
`endif
        .code_out  (code_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Data fills non-power-of-two positions in order; parity at 2^i covers positions with bit i set.
    function automatic logic [7:1] ref_encode(input logic [3:0] d);
        logic [7:1] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[j];
                j++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            logic par;
            par = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if (pos != (1 << i) && ((pos >> i) & 1) == 1) par = par ^ c[pos];
            c[1 << i] = par;
        end
        return c;
    endfunction

    function automatic logic [2:0] syndrome(input logic [7:1] c);
        int s;
        s = 0;
        for (int pos = 1; pos <= 7; pos++)
            if (c[pos]) s = s ^ pos;
        return 3'(s);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 8'(out_valid), 8'(exp_valid));
        check({tag, ".code"}, 8'(code_out), 8'(exp_code));
`ifdef HAM_ENC_SECDED_EN
        check({tag, ".p0"}, 8'(code_p0), 8'(^exp_code));
`endif
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [4:1] d);
        @(negedge clk);
        in_valid = v;
        data_in  = d;
        @(posedge clk);
        #1;
        exp_valid = v;
        if (v) exp_code = ref_encode(d);
    endtask

    logic [4:1] dir_data [6];
    logic [7:1] dir_code [6];
    logic [7:1] flipped;
    logic [4:1] rnd_d;
    logic       rnd_v;

    initial begin
        dir_data = '{4'b1100, 4'b1010, 4'b0001, 4'b0010, 4'b0011, 4'b0100};
        dir_code = '{7'b1100001, 7'b1010010, 7'b0000111, 7'b0011001, 7'b0011110, 7'b0101010};
        rst_n    = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        exp_code = '0;
        exp_valid = 1'b0;

        // Reset asserted before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check_outputs("reset");

        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors against hand-computed codewords
        step(1'b1, 4'b1100);
        check("p1_1100", 8'(dut.p1), 8'd1);
        check("p2_1100", 8'(dut.p2), 8'd0);
        check("p3_1100", 8'(dut.p3), 8'd0);
`ifdef HAM_ENC_SECDED_EN
        check("p0_1100", 8'(code_p0), 8'd1);
`endif
        for (int i = 0; i < 6; i++) begin
            if (i != 0) step(1'b1, dir_data[i]);
            check($sformatf("dir_%b", dir_data[i]), 8'(code_out), 8'(dir_code[i]));
            check($sformatf("dir_valid_%b", dir_data[i]), 8'(out_valid), 8'd1);
        end

        // Drop in_valid: valid clears, code holds while data_in wiggles
        step(1'b0, 4'hF);
        check_outputs("idle_hold0");
        step(1'b0, 4'h5);
        check_outputs("idle_hold1");

        // Exhaustive: model match, zero syndrome, single flips decode to their position
        for (int d = 0; d < 16; d++) begin
            step(1'b1, 4'(d));
            check_outputs($sformatf("exh_%0d", d));
            check($sformatf("syn0_%0d", d), 8'(syndrome(code_out)), 8'd0);
            for (int k = 1; k <= 7; k++) begin
                flipped = code_out ^ 7'(1 << (k - 1));
                check($sformatf("synflip_%0d_%0d", d, k), 8'(syndrome(flipped)), 8'(k));
            end
            if (d == 0)  check("all_zero", 8'(code_out), 8'b0000000);
            if (d == 15) check("all_one", 8'(code_out), 8'b1111111);
        end

        // Random back-to-back traffic with occasional idle cycles
        for (int n = 0; n < 300; n++) begin
            rnd_v = ($urandom_range(0, 3) != 0);
            rnd_d = 4'($urandom_range(0, 15));
            step(rnd_v, rnd_d);
            check_outputs($sformatf("rnd_%0d", n));
        end

        // Reset asserted between edges clears outputs immediately
        step(1'b1, 4'h9);
        check_outputs("pre_midreset");
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 4'h6;
        #2 rst_n = 1'b0;
        #1;
        exp_code  = '0;
        exp_valid = 1'b0;
        check_outputs("midreset_immediate");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_code  = ref_encode(4'h6);
        exp_valid = 1'b1;
        check_outputs("first_after_release");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
